// File: rtl/hsv2rgb.sv
// Four-stage pipelined HSV to RGB converter, 8 bits per channel.
// Hue 0..255 covers one full turn. Sideband flags travel with the data.
module hsv2rgb #(
  parameter bit         FIXED_SV  = 1'b0,
  parameter logic [7:0] SAT_CONST = 8'd255,
  parameter logic [7:0] VAL_CONST = 8'd255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_hue,
  input  logic [7:0] in_sat,
  input  logic [7:0] in_val,
  input  logic       in_visual,
  input  logic       in_done,
  output logic       out_valid,
  output logic [7:0] out_red,
  output logic [7:0] out_green,
  output logic [7:0] out_blue,
  output logic       out_visual,
  output logic       out_done
);

  // Sideband packing used in every stage: {valid, visual, done}
  logic [2:0]  s1_side_r, s2_side_r, s3_side_r;

  logic [10:0] h6_s;
  logic [7:0]  sat_s, val_s;
  logic [10:0] s1_h6_r;
  logic [7:0]  s1_sat_r, s1_val_r;

  logic [7:0]  f_s;
  logic [8:0]  nf_s, a_s, b_s, c_s;
  logic [8:0]  s2_a_r, s2_b_r, s2_c_r;
  logic [7:0]  s2_val_r;
  logic [2:0]  s2_sector_r;

  logic [7:0]  p_s, q_s, t_s;
  logic [7:0]  s3_p_r, s3_q_r, s3_t_r, s3_val_r;
  logic [2:0]  s3_sector_r;

  logic [7:0]  red_s, green_s, blue_s;

  // Stage 1 combinational: hue*6 as shift-add, saturation/value source select
  always_comb begin
    h6_s = {1'b0, in_hue, 2'b00} + {2'b00, in_hue, 1'b0};
    if (FIXED_SV) begin
      sat_s = SAT_CONST;
      val_s = VAL_CONST;
    end else begin
      sat_s = in_sat;
      val_s = in_val;
    end
  end

  // Stage 2 combinational: fractional position in sector and the three scale factors
  always_comb begin
    f_s  = s1_h6_r[7:0];
    nf_s = 9'd256 - {1'b0, f_s};
    a_s  = 9'd256 - {1'b0, s1_sat_r};
    b_s  = 9'd256 - 9'((16'(s1_sat_r) * 16'(f_s)) >> 8);
    c_s  = 9'd256 - 9'((17'(s1_sat_r) * 17'(nf_s)) >> 8);
  end

  // Stage 3 combinational: scale V by each factor; factors never exceed 256 so results fit 8 bits
  always_comb begin
    p_s = 8'((17'(s2_val_r) * 17'(s2_a_r)) >> 8);
    q_s = 8'((17'(s2_val_r) * 17'(s2_b_r)) >> 8);
    t_s = 8'((17'(s2_val_r) * 17'(s2_c_r)) >> 8);
  end

  // Stage 4 combinational: route V/p/q/t to RGB by sector
  always_comb begin
    red_s   = 8'd0;
    green_s = 8'd0;
    blue_s  = 8'd0;
    case (s3_sector_r)
      3'd0: begin red_s = s3_val_r; green_s = s3_t_r;   blue_s = s3_p_r;   end
      3'd1: begin red_s = s3_q_r;   green_s = s3_val_r; blue_s = s3_p_r;   end
      3'd2: begin red_s = s3_p_r;   green_s = s3_val_r; blue_s = s3_t_r;   end
      3'd3: begin red_s = s3_p_r;   green_s = s3_q_r;   blue_s = s3_val_r; end
      3'd4: begin red_s = s3_t_r;   green_s = s3_p_r;   blue_s = s3_val_r; end
      3'd5: begin red_s = s3_val_r; green_s = s3_p_r;   blue_s = s3_q_r;   end
      default: begin red_s = 8'd0; green_s = 8'd0; blue_s = 8'd0; end
    endcase
  end

  // Pipeline registers; reset clears every stage so no flushed pixel or done pulse survives
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_side_r   <= 3'b000;
      s1_h6_r     <= 11'd0;
      s1_sat_r    <= 8'd0;
      s1_val_r    <= 8'd0;
      s2_side_r   <= 3'b000;
      s2_a_r      <= 9'd0;
      s2_b_r      <= 9'd0;
      s2_c_r      <= 9'd0;
      s2_val_r    <= 8'd0;
      s2_sector_r <= 3'd0;
      s3_side_r   <= 3'b000;
      s3_p_r      <= 8'd0;
      s3_q_r      <= 8'd0;
      s3_t_r      <= 8'd0;
      s3_val_r    <= 8'd0;
      s3_sector_r <= 3'd0;
      out_valid   <= 1'b0;
      out_visual  <= 1'b0;
      out_done    <= 1'b0;
      out_red     <= 8'd0;
      out_green   <= 8'd0;
      out_blue    <= 8'd0;
    end else begin
      s1_side_r   <= {in_valid, in_visual, in_done};
      s1_h6_r     <= h6_s;
      s1_sat_r    <= sat_s;
      s1_val_r    <= val_s;
      s2_side_r   <= s1_side_r;
      s2_a_r      <= a_s;
      s2_b_r      <= b_s;
      s2_c_r      <= c_s;
      s2_val_r    <= s1_val_r;
      s2_sector_r <= s1_h6_r[10:8];
      s3_side_r   <= s2_side_r;
      s3_p_r      <= p_s;
      s3_q_r      <= q_s;
      s3_t_r      <= t_s;
      s3_val_r    <= s2_val_r;
      s3_sector_r <= s2_sector_r;
      out_valid   <= s3_side_r[2];
      out_visual  <= s3_side_r[1];
      out_done    <= s3_side_r[0];
      out_red     <= red_s;
      out_green   <= green_s;
      out_blue    <= blue_s;
    end
  end

endmodule

// File: tb/tb_hsv2rgb.sv
// Self-checking bench for hsv2rgb: directed vector table plus streaming,
// hue sweep, fixed-S/V instance and mid-stream reset sequences.
module tb_hsv2rgb;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in_valid, in_visual, in_done;
  logic [7:0] in_hue, in_sat, in_val;
  logic       out_valid, out_visual, out_done;
  logic [7:0] out_red, out_green, out_blue;
  logic       fx_valid, fx_visual, fx_done;
  logic [7:0] fx_red, fx_green, fx_blue;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] h, s, v, r, g, b;
  } vec_t;

  vec_t vecs[11];

  always #5 clock = ~clock;

  hsv2rgb dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_hue(in_hue),
    .in_sat(in_sat), .in_val(in_val), .in_visual(in_visual), .in_done(in_done),
    .out_valid(out_valid), .out_red(out_red), .out_green(out_green),
    .out_blue(out_blue), .out_visual(out_visual), .out_done(out_done)
  );

  hsv2rgb #(.FIXED_SV(1'b1), .SAT_CONST(8'd255), .VAL_CONST(8'd255)) dut_fix (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_hue(in_hue),
    .in_sat(in_sat), .in_val(in_val), .in_visual(in_visual), .in_done(in_done),
    .out_valid(fx_valid), .out_red(fx_red), .out_green(fx_green),
    .out_blue(fx_blue), .out_visual(fx_visual), .out_done(fx_done)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] h, input logic [7:0] s,
                       input logic [7:0] val, input logic vis, input logic dn);
    in_valid  = v;
    in_hue    = h;
    in_sat    = s;
    in_val    = val;
    in_visual = vis;
    in_done   = dn;
  endtask

  task automatic run_pixel(input int idx, input vec_t vc);
    @(negedge clock);
    drive(1'b1, vc.h, vc.s, vc.v, 1'b0, 1'b0);
    @(negedge clock);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    check($sformatf("vec%0d_valid", idx), int'(out_valid), 1);
    check($sformatf("vec%0d_red", idx),   int'(out_red),   int'(vc.r));
    check($sformatf("vec%0d_green", idx), int'(out_green), int'(vc.g));
    check($sformatf("vec%0d_blue", idx),  int'(out_blue),  int'(vc.b));
    @(negedge clock);
    check($sformatf("vec%0d_valid_drop", idx), int'(out_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] spat;
    int         mx;

    // h, s, v -> expected r, g, b (hand computed, truncating arithmetic)
    vecs[0]  = '{h: 8'd0,   s: 8'd255, v: 8'd255, r: 8'd255, g: 8'd0,   b: 8'd0};
    vecs[1]  = '{h: 8'd85,  s: 8'd255, v: 8'd255, r: 8'd2,   g: 8'd255, b: 8'd0};
    vecs[2]  = '{h: 8'd170, s: 8'd255, v: 8'd255, r: 8'd0,   g: 8'd4,   b: 8'd255};
    vecs[3]  = '{h: 8'd123, s: 8'd0,   v: 8'd200, r: 8'd200, g: 8'd200, b: 8'd200};
    vecs[4]  = '{h: 8'd50,  s: 8'd200, v: 8'd0,   r: 8'd0,   g: 8'd0,   b: 8'd0};
    vecs[5]  = '{h: 8'd43,  s: 8'd255, v: 8'd255, r: 8'd254, g: 8'd255, b: 8'd0};
    vecs[6]  = '{h: 8'd128, s: 8'd255, v: 8'd255, r: 8'd0,   g: 8'd255, b: 8'd255};
    vecs[7]  = '{h: 8'd213, s: 8'd255, v: 8'd255, r: 8'd254, g: 8'd0,   b: 8'd255};
    vecs[8]  = '{h: 8'd255, s: 8'd255, v: 8'd255, r: 8'd255, g: 8'd0,   b: 8'd6};
    vecs[9]  = '{h: 8'd20,  s: 8'd128, v: 8'd100, r: 8'd100, g: 8'd73,  b: 8'd50};
    vecs[10] = '{h: 8'd100, s: 8'd64,  v: 8'd200, r: 8'd150, g: 8'd200, b: 8'd167};

    reset_n = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    #1;
    check("rst_valid",  int'(out_valid),  0);
    check("rst_red",    int'(out_red),    0);
    check("rst_green",  int'(out_green),  0);
    check("rst_blue",   int'(out_blue),   0);
    check("rst_visual", int'(out_visual), 0);
    check("rst_done",   int'(out_done),   0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("post_rst_valid", int'(out_valid), 0);
    end

    for (int i = 0; i < 11; i++) run_pixel(i, vecs[i]);

    // FIXED_SV instance ignores in_sat/in_val; default instance uses them
    @(negedge clock);
    drive(1'b1, 8'd0, 8'd10, 8'd30, 1'b0, 1'b0);
    @(negedge clock);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    check("fix_valid", int'(fx_valid),  1);
    check("fix_red",   int'(fx_red),    255);
    check("fix_green", int'(fx_green),  0);
    check("fix_blue",  int'(fx_blue),   0);
    check("var_red",   int'(out_red),   30);
    check("var_green", int'(out_green), 28);
    check("var_blue",  int'(out_blue),  28);
    repeat (2) @(negedge clock);

    // Streaming: valid 1,1,0,1, done on 4th, visual high across all four
    spat = 4'b1011;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      check($sformatf("strm_valid_%0d", k), int'(out_valid),
            (k >= 4 && k < 8) ? int'(spat[k-4]) : 0);
      check($sformatf("strm_done_%0d", k), int'(out_done), (k == 7) ? 1 : 0);
      check($sformatf("strm_visual_%0d", k), int'(out_visual), (k >= 4 && k < 8) ? 1 : 0);
      if (k < 4) drive(spat[k], 8'(k * 40), 8'd255, 8'd255, 1'b1, k == 3);
      else       drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    end

    // Full hue sweep at S=V=255: one component must always be 255
    for (int k = 0; k < 260; k++) begin
      @(negedge clock);
      if (k >= 4) begin
        mx = int'(out_red);
        if (int'(out_green) > mx) mx = int'(out_green);
        if (int'(out_blue) > mx)  mx = int'(out_blue);
        check($sformatf("sweep_valid_h%0d", k - 4), int'(out_valid), 1);
        check($sformatf("sweep_max_h%0d", k - 4), mx, 255);
        check($sformatf("sweep_known_h%0d", k - 4),
              int'($isunknown({out_red, out_green, out_blue})), 0);
      end
      if (k < 256) drive(1'b1, 8'(k), 8'd255, 8'd255, 1'b0, 1'b0);
      else         drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    end
    repeat (2) @(negedge clock);

    // Mid-stream reset: first pixel at output, three more in flight (one carries done)
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      drive(1'b1, 8'd0, 8'd255, 8'd255, 1'b1, k == 2);
    end
    @(negedge clock);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    check("mid_pre_valid", int'(out_valid), 1);
    check("mid_pre_red",   int'(out_red),   255);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid",  int'(out_valid),  0);
    check("mid_rst_red",    int'(out_red),    0);
    check("mid_rst_green",  int'(out_green),  0);
    check("mid_rst_blue",   int'(out_blue),   0);
    check("mid_rst_visual", int'(out_visual), 0);
    check("mid_rst_done",   int'(out_done),   0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check($sformatf("flush_valid_%0d", k), int'(out_valid), 0);
      check($sformatf("flush_done_%0d", k),  int'(out_done),  0);
    end
    @(negedge clock);
    drive(1'b1, 8'd85, 8'd255, 8'd255, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      if (i == 1) drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      check($sformatf("relaunch_valid_%0d", i), int'(out_valid), (i == 4) ? 1 : 0);
    end
    check("relaunch_red",   int'(out_red),   2);
    check("relaunch_green", int'(out_green), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hsv2rgb.md
Name: hsv2rgb

Overview:
- Fixed-latency pipelined converter from 8-bit hue/saturation/value pixels back to 8-bit RGB.
- Used on the visualisation path to render hue-classified pixels as displayable colour.
- Hue encoding matches the camera hue stage: 0..255 spans one full circle, where 256 would equal 360 degrees.
- Carries visual/done sideband flags alongside the data, with matching latency.

Parameters:
- FIXED_SV, 0, when 1 ignore in_sat/in_val and use SAT_CONST/VAL_CONST (hue-only colouring).
- SAT_CONST, 255, saturation used when FIXED_SV=1.
- VAL_CONST, 255, value used when FIXED_SV=1.

Ports:
- clock  in  1  single system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input pixel qualifier
- in_hue  in  8  hue, 0..255 = 0..360 deg
- in_sat  in  8  saturation
- in_val  in  8  value (brightness)
- in_visual  in  1  sideband, delayed with data
- in_done  in  1  end-of-frame sideband, delayed with data
- out_valid  out  1  output pixel qualifier
- out_red  out  8  red component
- out_green  out  8  green component
- out_blue  out  8  blue component
- out_visual  out  1  delayed in_visual
- out_done  out  1  delayed in_done

Behaviour:
- Reset:
  - reset_n low asynchronously clears every pipeline register; all outputs read 0 while reset is asserted.
  - After release, out_valid stays 0 until valid data has traversed the pipe. No spurious valid is produced from flushed stages.
- Flow control:
  - No backpressure; every stage advances every clock.
  - Data registers load regardless of in_valid. Outputs are meaningful only when out_valid=1.
  - Latency is exactly 4 clocks for data, valid, visual and done.
  - Back-to-back valid inputs are accepted every cycle.
- S1: register h6 = in_hue*6 (11 bits, max 1530), S, V (or constants) and sideband.
- S2:
  - sector = h6[10:8], range 0..5; the value 6/7 is unreachable.
  - f = h6[7:0].
  - a = 256-S (9 bits).
  - b = 256-((S*f)>>8).
  - c = 256-((S*(256-f))>>8).
  - Register a, b, c, V, sector and sideband.
- S3:
  - p = (V*a)>>8.
  - q = (V*b)>>8.
  - t = (V*c)>>8.
  - All products are unsigned 17-bit; results are truncated to 8 bits and never exceed V.
- S4: output mux, (R,G,B) by sector:
  - 0 = (V,t,p)
  - 1 = (q,V,p)
  - 2 = (p,V,t)
  - 3 = (p,q,V)
  - 4 = (t,p,V)
  - 5 = (V,p,q)
- Arithmetic rules:
  - No rounding; truncation only.
  - S=0 must yield R=G=B=V exactly.
  - V=0 must yield black for any H and S.
- Reset asserted mid-stream discards all in-flight pixels, including any in-flight done pulse. The upstream block re-issues framing.

Test Plan:
- Primary red: H=0, S=255, V=255, valid one cycle -> 4 clocks later out_valid=1, RGB=(255,0,0); out_valid=0 next cycle.
- Green region: H=85, S=255, V=255 -> sector 1, f=254 -> RGB=(2,255,0).
- Blue region: H=170, S=255, V=255 -> sector 3, f=252 -> RGB=(0,4,255).
- Grey: S=0, V=200, H=123 -> RGB=(200,200,200). With FIXED_SV=1 (255/255) and H=0, the RGB outputs are (255,0,0) irrespective of in_sat/in_val.
- Streaming:
  - in_valid pattern 1,1,0,1 with in_done on the 4th pixel and in_visual=1 throughout.
  - Required: out_valid reproduces 1,1,0,1 delayed by exactly 4 clocks, and out_done is high only with the 4th pixel.
  - Sweep H=0..255 at S=V=255: every output has max component 255; no X values.
- Reset mid-stream: assert reset_n low between clock edges while 3 pixels are in flight -> outputs go 0 immediately. After release, out_valid stays 0 until the next valid input plus 4 clocks.
